// File: rtl/sprite_rom_arbiter_if.sv
// Bundle of the requester-side and ROM-side signals around the sprite ROM arbiter.
// The master modport is the requesters plus the ROM. The slave modport is the arbiter.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rom_rd;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_q;
  logic                      busy;

  modport master (
    output req_valid, req_addr, rom_q,
    input  req_ready, rsp_valid, rsp_data, rom_rd, rom_addr, busy
  );

  modport slave (
    input  req_valid, req_addr, rom_q,
    output req_ready, rsp_valid, rsp_data, rom_rd, rom_addr, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one single-port sprite/palette ROM among NUM_REQ pixel requesters.
// A tag pipe matched to the ROM latency steers each returned word back to the requester that asked for it.
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int ROM_LATENCY = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  sprite_rom_arbiter_if.slave arb
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = ROM_LATENCY + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   r_ptr;
  logic [DEPTH-1:0]   r_vld_p;
  logic [IDX_W-1:0]   r_idx_p [DEPTH];
  logic               r_rom_rd;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_accept;
  logic [ADDR_W-1:0]  w_gnt_addr;

  // Walk the requesters starting at r_ptr. The first valid one wins, and idle ones cost no cycle.
  always_comb begin : arb_search
    logic [IDX_W-1:0] cand;
    w_grant   = '0;
    w_gnt_idx = '0;
    w_accept  = 1'b0;
    cand      = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_accept && !Reset && arb.req_valid[cand]) begin
        w_accept  = 1'b1;
        w_gnt_idx = cand;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
    end
    if (w_accept) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  assign w_gnt_addr = arb.req_addr[w_gnt_idx*ADDR_W +: ADDR_W];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ptr       <= '0;
      r_vld_p     <= '0;
      r_rom_rd    <= 1'b0;
      r_rom_addr  <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        r_idx_p[j] <= '0;
      end
    end else begin
      // Stage 0: accepted request drives the ROM, and its tag enters the pipe.
      r_rom_rd   <= w_accept;
      r_vld_p    <= {r_vld_p[DEPTH-2:0], w_accept};
      r_idx_p[0] <= w_gnt_idx;
      for (int j = 1; j < DEPTH; j++) begin
        r_idx_p[j] <= r_idx_p[j-1];
      end
      if (w_accept) begin
        r_rom_addr <= w_gnt_addr;
        r_ptr      <= (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
      end
      // Last stage: ROM data is valid now, so route it to the tagged requester.
      r_rsp_valid <= '0;
      if (r_vld_p[DEPTH-1]) begin
        r_rsp_valid[r_idx_p[DEPTH-1]] <= 1'b1;
        r_rsp_data                    <= arb.rom_q;
      end
    end
  end

  assign arb.req_ready = w_grant;
  assign arb.rsp_valid = r_rsp_valid;
  assign arb.rsp_data  = r_rsp_data;
  assign arb.rom_rd    = r_rom_rd;
  assign arb.rom_addr  = r_rom_addr;
  assign arb.busy      = (|r_vld_p) | w_accept;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: the default configuration, plus two NUM_REQ=2 instances
// with ROM_LATENCY 1 and 4 that share a random-valid stream and are checked against a grant/response model.
module tb_sprite_rom_arbiter;
  logic Clk;
  logic Reset;

  sprite_rom_arbiter_if #(.NUM_REQ(3), .ADDR_W(17), .DATA_W(8)) bus  ();
  sprite_rom_arbiter_if #(.NUM_REQ(2), .ADDR_W(17), .DATA_W(8)) bus1 ();
  sprite_rom_arbiter_if #(.NUM_REQ(2), .ADDR_W(17), .DATA_W(8)) bus4 ();

  sprite_rom_arbiter #(.NUM_REQ(3), .ADDR_W(17), .DATA_W(8), .ROM_LATENCY(2)) dut (
    .Clk(Clk), .Reset(Reset), .arb(bus));
  sprite_rom_arbiter #(.NUM_REQ(2), .ADDR_W(17), .DATA_W(8), .ROM_LATENCY(1)) dut_l1 (
    .Clk(Clk), .Reset(Reset), .arb(bus1));
  sprite_rom_arbiter #(.NUM_REQ(2), .ADDR_W(17), .DATA_W(8), .ROM_LATENCY(4)) dut_l4 (
    .Clk(Clk), .Reset(Reset), .arb(bus4));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ROM models: q = addr[7:0], valid ROM_LATENCY edges after the address is registered
  logic [16:0] rom2_p [2];
  logic [16:0] rom1_p;
  logic [16:0] rom4_p [4];
  always @(posedge Clk) begin
    rom2_p[0] <= bus.rom_addr;
    rom2_p[1] <= rom2_p[0];
    rom1_p    <= bus1.rom_addr;
    rom4_p[0] <= bus4.rom_addr;
    rom4_p[1] <= rom4_p[0];
    rom4_p[2] <= rom4_p[1];
    rom4_p[3] <= rom4_p[2];
  end
  assign bus.rom_q  = rom2_p[1][7:0];
  assign bus1.rom_q = rom1_p[7:0];
  assign bus4.rom_q = rom4_p[3][7:0];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [16:0] a0, input logic [16:0] a1,
                       input logic [16:0] a2);
    bus.req_valid = v;
    bus.req_addr  = {a2, a1, a0};
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    drive(3'b000, 17'h0, 17'h0, 17'h0);
    tick();
    Reset = 1'b0;
  endtask

  logic [2:0]  oh3  [3];
  logic [7:0]  dat3 [3];
  logic [16:0] adr3 [3];

  // Sweep scoreboard: expected response per cycle index
  logic [1:0]  e1_v [1010];
  logic [7:0]  e1_d [1010];
  logic [1:0]  e4_v [1010];
  logic [7:0]  e4_d [1010];
  logic [1:0]  sv;
  logic [16:0] sa [2];
  int          m_ptr, g, n_acc, n_rsp1, n_rsp4;
  logic [1:0]  exp_rdy;

  initial begin
    oh3  = '{3'b001, 3'b010, 3'b100};
    dat3 = '{8'h10, 8'h21, 8'h32};
    adr3 = '{17'h010, 17'h021, 17'h032};
    bus1.req_valid = '0; bus1.req_addr = '0;
    bus4.req_valid = '0; bus4.req_addr = '0;

    // Reset state; grants are suppressed while Reset is high
    Reset = 1'b1;
    drive(3'b111, 17'h0, 17'h0, 17'h0);
    #1;
    chk("rst_ready", bus.req_ready, 3'b000);
    tick();
    chk("rst_rom_rd", bus.rom_rd, 1'b0);
    chk("rst_rom_addr", bus.rom_addr, 17'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 3'b000);
    chk("rst_rsp_data", bus.rsp_data, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);

    // Single stream on requester 1
    Reset = 1'b0;
    drive(3'b010, 17'h0, 17'h100, 17'h0);
    #1;
    chk("ss_ready0", bus.req_ready, 3'b010);
    tick();
    chk("ss_rom_rd", bus.rom_rd, 1'b1);
    chk("ss_rom_addr", bus.rom_addr, 17'h100);
    drive(3'b010, 17'h0, 17'h101, 17'h0);
    #1;
    chk("ss_ready1", bus.req_ready, 3'b010);
    tick();
    drive(3'b010, 17'h0, 17'h102, 17'h0);
    #1;
    chk("ss_ready2", bus.req_ready, 3'b010);
    tick();
    drive(3'b000, 17'h0, 17'h0, 17'h0);
    tick();
    chk("ss_rsp0", bus.rsp_valid, 3'b010);
    chk("ss_dat0", bus.rsp_data, 8'h00);
    chk("ss_busy_mid", bus.busy, 1'b1);
    tick();
    chk("ss_rsp1", bus.rsp_valid, 3'b010);
    chk("ss_dat1", bus.rsp_data, 8'h01);
    tick();
    chk("ss_rsp2", bus.rsp_valid, 3'b010);
    chk("ss_dat2", bus.rsp_data, 8'h02);
    chk("ss_busy_end", bus.busy, 1'b0);
    tick();
    chk("ss_rsp_idle", bus.rsp_valid, 3'b000);
    chk("ss_dat_hold", bus.rsp_data, 8'h02);

    // Round-robin with all requesters valid
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive((c < 6) ? 3'b111 : 3'b000, adr3[0], adr3[1], adr3[2]);
      #1;
      if (c < 6) chk("rr_ready", bus.req_ready, oh3[c%3]);
      tick();
      if (c < 6) chk("rr_rom_addr", bus.rom_addr, adr3[c%3]);
      if (c >= 3) begin
        chk("rr_rsp", bus.rsp_valid, oh3[(c-3)%3]);
        chk("rr_dat", bus.rsp_data, dat3[(c-3)%3]);
      end
    end

    // Skip/wrap: move ptr to 2, then only requesters 0 and 1 are valid
    drive(3'b010, 17'h0, 17'h0AA, 17'h0);
    #1;
    chk("sk_pre", bus.req_ready, 3'b010);
    tick();
    drive(3'b011, 17'h0A0, 17'h0A1, 17'h0);
    #1;
    chk("sk_ready0", bus.req_ready, 3'b001);
    tick();
    chk("sk_addr0", bus.rom_addr, 17'h0A0);
    #1;
    chk("sk_ready1", bus.req_ready, 3'b010);
    tick();
    chk("sk_addr1", bus.rom_addr, 17'h0A1);
    chk("sk_rd1", bus.rom_rd, 1'b1);
    #1;
    chk("sk_ready2", bus.req_ready, 3'b001);
    tick();
    chk("sk_addr2", bus.rom_addr, 17'h0A0);
    chk("sk_rd2", bus.rom_rd, 1'b1);
    drive(3'b000, 17'h0, 17'h0, 17'h0);
    repeat (4) tick();

    // Stall: requester 2 joins requesters 0 and 1 (ptr is 1 here)
    drive(3'b111, 17'h055, 17'h066, 17'h1ABCD);
    #1;
    chk("st_ready0", bus.req_ready, 3'b010);
    tick();
    #1;
    chk("st_ready1", bus.req_ready, 3'b100);
    tick();
    chk("st_rom_addr", bus.rom_addr, 17'h1ABCD);
    drive(3'b011, 17'h055, 17'h066, 17'h0);
    #1;
    chk("st_ready2", bus.req_ready, 3'b001);
    tick();
    #1;
    chk("st_ready3", bus.req_ready, 3'b010);
    tick();
    chk("st_rsp1", bus.rsp_valid, 3'b010);
    chk("st_dat1", bus.rsp_data, 8'h66);
    drive(3'b000, 17'h0, 17'h0, 17'h0);
    tick();
    chk("st_rsp2", bus.rsp_valid, 3'b100);
    chk("st_dat2", bus.rsp_data, 8'hCD);
    repeat (3) tick();

    // Reset mid-flight (ptr is 2 here)
    drive(3'b100, 17'h0, 17'h0, 17'h0B2);
    #1;
    chk("rm_ready0", bus.req_ready, 3'b100);
    tick();
    drive(3'b010, 17'h0, 17'h0B1, 17'h0);
    #1;
    chk("rm_ready1", bus.req_ready, 3'b010);
    tick();
    Reset = 1'b1;
    drive(3'b111, 17'h0, 17'h0, 17'h0);
    #1;
    chk("rm_ready_rst", bus.req_ready, 3'b000);
    tick();
    chk("rm_busy", bus.busy, 1'b0);
    Reset = 1'b0;
    drive(3'b000, 17'h0, 17'h0, 17'h0);
    for (int i = 0; i < 5; i++) begin
      chk("rm_rsp_quiet", bus.rsp_valid, 3'b000);
      chk("rm_rom_rd", bus.rom_rd, 1'b0);
      tick();
    end
    drive(3'b111, 17'h0, 17'h0, 17'h0);
    #1;
    chk("rm_next_grant", bus.req_ready, 3'b001);
    tick();
    drive(3'b000, 17'h0, 17'h0, 17'h0);
    repeat (4) tick();

    // Latency sweep on the NUM_REQ=2 instances with random valids
    do_reset();
    for (int i = 0; i < 1010; i++) begin
      e1_v[i] = '0; e1_d[i] = '0; e4_v[i] = '0; e4_d[i] = '0;
    end
    sv = '0; sa[0] = '0; sa[1] = '0;
    m_ptr = 0; n_acc = 0; n_rsp1 = 0; n_rsp4 = 0;
    for (int t = 0; t < 1006; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (t < 1000 && !sv[i] && $urandom_range(0, 99) < 60) begin
          sv[i] = 1'b1;
          sa[i] = 17'($urandom);
        end
      end
      bus1.req_valid = sv; bus1.req_addr = {sa[1], sa[0]};
      bus4.req_valid = sv; bus4.req_addr = {sa[1], sa[0]};
      g = -1;
      if (sv[m_ptr]) g = m_ptr;
      else if (sv[1-m_ptr]) g = 1 - m_ptr;
      exp_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
      #1;
      chk("sw_ready_l1", bus1.req_ready, exp_rdy);
      chk("sw_ready_l4", bus4.req_ready, exp_rdy);
      if (g >= 0) begin
        e1_v[t+2] = exp_rdy; e1_d[t+2] = sa[g][7:0];
        e4_v[t+5] = exp_rdy; e4_d[t+5] = sa[g][7:0];
        n_acc++;
        m_ptr = 1 - g;
        sv[g] = 1'b0;
      end
      tick();
      chk("sw_rsp_l1", bus1.rsp_valid, e1_v[t]);
      chk("sw_rsp_l4", bus4.rsp_valid, e4_v[t]);
      if (e1_v[t] != 2'b00) chk("sw_dat_l1", bus1.rsp_data, e1_d[t]);
      if (e4_v[t] != 2'b00) chk("sw_dat_l4", bus4.rsp_data, e4_d[t]);
      n_rsp1 += $countones(bus1.rsp_valid);
      n_rsp4 += $countones(bus4.rsp_valid);
    end
    chk("sw_count_l1", n_rsp1, n_acc);
    chk("sw_count_l4", n_rsp4, n_acc);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
